// File: rtl/csi2tx_dpcm_encoder.sv
// DPCM encoder stage: raw pixels to 8-bit codes (10-8-10 / 12-8-12) or bypass.
// Optional macro CSI2TX_DPCM_STATS_EN builds the per-line saturation counter.
module csi2tx_dpcm_encoder (
   input  logic        sensor_clk,
   input  logic        sys_rst_n,
   input  logic [4:0]  comp_scheme,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic        pix_sol,
   input  logic [11:0] pix_data,
   input  logic [11:0] pred_data,
   output logic        enable,
   output logic [11:0] dec_data,
   output logic        pixel1_valid,
   output logic        pixel2_valid,
   output logic        pixel3_valid,
   output logic        pixel4_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_data,
   output logic [15:0] sat_count
);

   logic        r_out_valid;
   logic [11:0] r_out_data;
   logic [2:0]  r_pos;

   logic        w_accept;
   logic        w_comp_en;
   logic        w_m12;
   logic        w_pcm;
   logic [11:0] w_x;
   logic [11:0] w_p;
   logic [12:0] w_diff;
   logic [12:0] w_abs;
   logic [11:0] w_m;
   logic        w_sat;
   logic [6:0]  w_mag;
   logic [11:0] w_step;
   logic [13:0] w_sum;
   logic [11:0] w_max;
   logic [7:0]  w_code;
   logic [11:0] w_dec;
   logic        w_unused;

   assign w_unused  = comp_scheme[4];
   assign w_accept  = pix_valid & pix_ready;
   assign pix_ready = ~r_out_valid | out_ready;
   assign w_comp_en = |comp_scheme[2:0];
   assign w_m12     = (comp_scheme[2:0] == 3'b010);
   assign enable    = w_accept & w_comp_en;

   // Position flags depend only on inputs and r_pos, never on pred_data.
   assign pixel1_valid = enable & (pix_sol | (r_pos == 3'd1));
   assign pixel2_valid = enable & ~pix_sol & (r_pos == 3'd2);
   assign pixel3_valid = enable & ~pix_sol & (r_pos == 3'd3);
   assign pixel4_valid = enable & ~pix_sol & (r_pos == 3'd4);

   assign w_pcm = pixel1_valid | (pixel2_valid & comp_scheme[3]);

   // Sample and prediction are truncated to the active pixel width.
   assign w_x   = w_m12 ? pix_data : {2'b00, pix_data[9:0]};
   assign w_p   = w_m12 ? pred_data : {2'b00, pred_data[9:0]};
   assign w_max = w_m12 ? 12'hFFF : 12'h3FF;

   assign w_diff = {1'b0, w_x} - {1'b0, w_p};
   assign w_abs  = w_diff[12] ? (~w_diff + 13'd1) : w_diff;
   assign w_m    = w_m12 ? w_abs[12:1] >> 2 : w_abs[12:1];
   assign w_sat  = enable & ~w_pcm & (w_m > 12'd127);
   assign w_mag  = (w_m > 12'd127) ? 7'd127 : w_m[6:0];
   assign w_step = w_m12 ? {2'b00, w_mag, 3'b000}
                         : {4'b0000, w_mag, 1'b0};
   assign w_sum  = w_diff[12] ? ({2'b00, w_p} - {2'b00, w_step})
                              : ({2'b00, w_p} + {2'b00, w_step});

   // Code and reconstruction for PCM or DPCM beats.
   always_comb begin
      w_code = 8'h00;
      w_dec  = 12'h000;
      if (w_pcm) begin
         if (w_m12) begin
            w_code = w_x[11:4];
            w_dec  = {w_x[11:4], 4'b1000};
         end else begin
            w_code = w_x[9:2];
            w_dec  = {2'b00, w_x[9:2], 2'b10};
         end
      end else begin
         w_code = {w_diff[12], w_mag};
         if (w_sum[13])
            w_dec = 12'h000;
         else if (w_sum[11:0] > w_max || w_sum[12])
            w_dec = w_max;
         else
            w_dec = w_sum[11:0];
      end
   end

   assign dec_data = enable ? w_dec : 12'h000;

   // Line position: pix_sol restarts at 2, otherwise counts up to 5.
   always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         r_pos <= 3'd1;
      else if (w_accept) begin
         if (pix_sol)
            r_pos <= 3'd2;
         else if (r_pos < 3'd5)
            r_pos <= r_pos + 3'd1;
      end
   end

   // Output register: load on accept, drain when taken, else hold.
   always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 12'h000;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_comp_en ? {4'h0, w_code} : pix_data;
      end else if (r_out_valid & out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef CSI2TX_DPCM_STATS_EN
   logic [15:0] r_sat_cnt;

   // Per-line count of saturated codes, restarted by pix_sol.
   always_ff @(posedge sensor_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         r_sat_cnt <= 16'h0000;
      else if (w_accept & pix_sol)
         r_sat_cnt <= {15'h0000, w_sat};
      else if (w_accept & w_sat & (r_sat_cnt != 16'hFFFF))
         r_sat_cnt <= r_sat_cnt + 16'h0001;
   end

   assign sat_count = r_sat_cnt;
`else
   assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_csi2tx_dpcm_encoder.sv
// Directed bench for csi2tx_dpcm_encoder.
// Expected values are hand-computed from the coding rules.
module tb_csi2tx_dpcm_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  comp_scheme;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sol;
   logic [11:0] pix_data;
   logic [11:0] pred_data;
   logic        enable;
   logic [11:0] dec_data;
   logic        p1, p2, p3, p4;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic [15:0] sat_count;

   int n_chk  = 0;
   int n_fail = 0;
   logic [15:0] exp_sat;

   always #5 clk = ~clk;

   csi2tx_dpcm_encoder dut (
      .sensor_clk   (clk),
      .sys_rst_n    (rst_n),
      .comp_scheme  (comp_scheme),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_sol      (pix_sol),
      .pix_data     (pix_data),
      .pred_data    (pred_data),
      .enable       (enable),
      .dec_data     (dec_data),
      .pixel1_valid (p1),
      .pixel2_valid (p2),
      .pixel3_valid (p3),
      .pixel4_valid (p4),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .sat_count    (sat_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one beat, check predictor-side signals before the edge
   // and the registered word after it.
   task automatic send(input string tag, input logic sol,
                       input logic [11:0] x, input logic [11:0] p,
                       input logic ena, input logic [11:0] edec,
                       input logic [3:0] eflg, input logic [11:0] eout);
      pix_valid = 1'b1;
      pix_sol   = sol;
      pix_data  = x;
      pred_data = p;
      @(negedge clk);
      chk({tag, "_ena"}, {31'b0, enable}, {31'b0, ena});
      chk({tag, "_dec"}, {20'b0, dec_data}, {20'b0, edec});
      chk({tag, "_pos"}, {28'b0, p4, p3, p2, p1}, {28'b0, eflg});
      @(posedge clk);
      #1;
      chk({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_od"}, {20'b0, out_data}, {20'b0, eout});
   endtask

   task automatic idle();
      pix_valid = 1'b0;
      pix_sol   = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      comp_scheme = 5'b00001;
      pix_valid   = 1'b0;
      pix_sol     = 1'b0;
      pix_data    = 12'h000;
      pred_data   = 12'h000;
      out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      chk("rst_ov",  {31'b0, out_valid}, 32'd0);
      chk("rst_od",  {20'b0, out_data}, 32'd0);
      chk("rst_sat", {16'b0, sat_count}, 32'd0);
      chk("rst_rdy", {31'b0, pix_ready}, 32'd1);
      chk("rst_ena", {31'b0, enable}, 32'd0);
      chk("rst_dec", {20'b0, dec_data}, 32'd0);
      chk("rst_pos", {28'b0, p4, p3, p2, p1}, 32'd0);

      // 10-8-10, predictor2
      comp_scheme = 5'b00001;
      send("a1", 1'b1, 12'h200, 12'h000, 1'b1, 12'h202, 4'b0001, 12'h080);
      send("a2", 1'b0, 12'h210, 12'h202, 1'b1, 12'h210, 4'b0010, 12'h007);
      send("a3", 1'b0, 12'h1F0, 12'h202, 1'b1, 12'h1F0, 4'b0100, 12'h089);
      idle();
      chk("a_drain", {31'b0, out_valid}, 32'd0);

      // 12-8-12 saturation
      comp_scheme = 5'b00010;
      send("b1", 1'b1, 12'h000, 12'h000, 1'b1, 12'h008, 4'b0001, 12'h000);
      send("b2", 1'b0, 12'hFFF, 12'h008, 1'b1, 12'h400, 4'b0010, 12'h07F);
`ifdef CSI2TX_DPCM_STATS_EN
      exp_sat = 16'd1;
`else
      exp_sat = 16'd0;
`endif
      chk("b_sat", {16'b0, sat_count}, {16'b0, exp_sat});
      idle();

      // predictor1: second beat of the line is also PCM
      comp_scheme = 5'b01001;
      send("c1", 1'b1, 12'h100, 12'h000, 1'b1, 12'h102, 4'b0001, 12'h040);
      send("c2", 1'b0, 12'h104, 12'h123, 1'b1, 12'h106, 4'b0010, 12'h041);
      idle();

      // backpressure then full-rate stream
      comp_scheme = 5'b00001;
      out_ready   = 1'b0;
      send("d0", 1'b1, 12'h300, 12'h000, 1'b1, 12'h302, 4'b0001, 12'h0C0);
      pix_sol   = 1'b0;
      pix_data  = 12'h304;
      pred_data = 12'h302;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("d_rdy", {31'b0, pix_ready}, 32'd0);
         chk("d_ena", {31'b0, enable}, 32'd0);
         chk("d_od",  {20'b0, out_data}, 32'h0C0);
         chk("d_ov",  {31'b0, out_valid}, 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send("d1", 1'b0, 12'h304, 12'h302, 1'b1, 12'h304, 4'b0010, 12'h001);
      send("d2", 1'b0, 12'h308, 12'h302, 1'b1, 12'h308, 4'b0100, 12'h003);
      send("d3", 1'b0, 12'h2F0, 12'h302, 1'b1, 12'h2F0, 4'b1000, 12'h089);
      send("d4", 1'b0, 12'h302, 12'h302, 1'b1, 12'h302, 4'b0000, 12'h000);
      idle();

      // bypass
      comp_scheme = 5'b00000;
      send("e1", 1'b1, 12'hABC, 12'h555, 1'b0, 12'h000, 4'b0000, 12'hABC);
      idle();

      // reset mid-line
      comp_scheme = 5'b00001;
      send("f1", 1'b1, 12'h200, 12'h000, 1'b1, 12'h202, 4'b0001, 12'h080);
      send("f2", 1'b0, 12'h210, 12'h202, 1'b1, 12'h210, 4'b0010, 12'h007);
      send("f3", 1'b0, 12'h1F0, 12'h202, 1'b1, 12'h1F0, 4'b0100, 12'h089);
      pix_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("f_ov", {31'b0, out_valid}, 32'd0);
      chk("f_od", {20'b0, out_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send("f4", 1'b0, 12'h100, 12'h000, 1'b1, 12'h102, 4'b0001, 12'h040);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/csi2tx_dpcm_encoder.md
# csi2tx_dpcm_encoder

DPCM encoder stage of the CSI-2 TX pixel-to-byte path. It accepts raw pixels from the sensor interface and drives the existing predictor with the enable, pixel-position and reconstructed-sample signals it needs. It combines the raw pixel with the predictor's `pred_data` to produce 8-bit compressed codes on a registered valid/ready output toward byte packing. When compression is off it passes raw pixels through unchanged.

## Interface
- No parameters.
- `sensor_clk` input 1 — pixel clock.
- `sys_rst_n` input 1 — asynchronous, active-low reset.
- `comp_scheme` input 5 — scheme select:
  - `[3]` selects predictor1; otherwise predictor2.
  - `[2:0]`: 3'b001 = 10-8-10; 3'b010 = 12-8-12.
  - All zero = bypass.
  - Any other nonzero value is treated as 10-8-10.
- `pix_valid` input 1 — input beat valid.
- `pix_ready` output 1 — input beat accepted when `pix_valid & pix_ready`.
- `pix_sol` input 1 — start of line; qualifies the first beat of a line.
- `pix_data` input 12 — raw pixel.
  - 10-bit modes use `[9:0]`; `[11:10]` are ignored.
- `pred_data` input 12 — prediction from the predictor (combinational).
- `enable` output 1 — to predictor; history shift strobe.
- `dec_data` output 12 — to predictor; reconstructed sample.
- `pixel1_valid` … `pixel4_valid` output 1 each — to predictor; position of the current beat in the line.
- `out_valid` output 1 — encoded word valid.
- `out_ready` input 1 — downstream accept.
- `out_data` output 12 — `{4'b0, code}` when compressing; raw pixel in bypass.
- `sat_count` output 16 — count of saturated DPCM codes in the current line.

## Operation
- `accept = pix_valid & pix_ready`.
- `pix_ready = ~out_valid | out_ready`.
- `comp_en = |comp_scheme[2:0]`.
- `enable = accept & comp_en` (combinational).
- **Position counter `pos_q`** (values 1..5, reset 1):
  - On `accept`: `pos_q` ← 2 if `pix_sol`, else `min(pos_q+1, 5)`.
  - `pixel1_valid = accept & (pix_sol | pos_q==1)`.
  - `pixelk_valid` (k = 2..4) `= accept & ~pix_sol & pos_q==k`.
  - Beats at position 5 and beyond assert no position flag.
  - Position outputs must be derived only from inputs and `pos_q`, never from `pred_data`, so no combinational loop forms through the predictor.
- **Mode parameters:** N = 10 or 12; PCM shift p = N−8 (2 or 4); DPCM shift s = 1 (10-bit) or 3 (12-bit).
- **PCM beats** are those with `pixel1_valid`, or `pixel2_valid` with `comp_scheme[3]`:
  - `code = X >> p`.
  - `dec = (code << p) + (1 << (p−1))`.
- **DPCM beats** (all other beats):
  - `diff = X − pred` (13-bit signed); `m = |diff| >> s`.
  - If `m > 127`: `mag = 127` and the beat is saturated; otherwise `mag = m`.
  - `code = {sign(diff), mag[6:0]}`.
  - `dec = clamp(pred ± (mag << s), 0, 2^N−1)`, with − when `diff` is negative.
- `dec_data` is combinational from `pix_data` and `pred_data`. It is 0 when `~enable`.
- **Bypass** (`comp_en` = 0): `out_data = pix_data`; `enable` and all `pixelk_valid` stay 0.
- **`sat_count`:** cleared on an accepted `pix_sol` beat. Incremented (saturating at 16'hFFFF) on each accepted saturated beat. An accepted `pix_sol` beat that is itself saturated loads 1.
- A `comp_scheme` change takes effect on the next accepted beat. The encoded values of the line in progress are then undefined.

## Timing
- Latency is 1 cycle: an accepted beat appears on `out_data` with `out_valid` high the next cycle.
- Output register update rules:
  - Load on `accept`.
  - Clear `out_valid` when `out_valid & out_ready & ~accept`.
  - Otherwise hold. `out_data` must stay stable while `out_valid & ~out_ready`.
- Simultaneous `out_ready` and a new beat give full throughput: one beat per cycle.
- The predictor shifts its history at the same edge that loads the output register.
- Reset values: `out_valid` 0, `out_data` 0, `sat_count` 0, `pos_q` 1.
- Combinational outputs with all inputs idle: `pix_ready` 1, `enable` 0, `dec_data` 0, all `pixelk_valid` 0.
- Reset asserted mid-line discards the output word. The next beat is treated as pixel1 even without `pix_sol`.

## Configuration
- `CSI2TX_DPCM_STATS_EN` defined: the `sat_count` logic is built as described.
- Undefined: `sat_count` is tied to 16'h0000 and no counter flops are built. All other behaviour is identical.

## Test plan
- **10-8-10, predictor2.** Stimulus: `pix_sol` with X=0x200, then X=0x210, then X=0x1F0. Required:
  - Codes 0x80, 0x07, 0x89.
  - `dec_data` 0x202, 0x210, 0x1F0.
  - `pixel1_valid`, `pixel2_valid`, `pixel3_valid` asserted on the respective beats.
- **12-8-12 saturation.** Stimulus: `pix_sol` X=0x000, then X=0xFFF. Required:
  - Codes 0x00, 0x7F.
  - `dec_data` 0x008, 0x400.
  - `sat_count` = 1 (macro on) or 0 (macro off).
- **Predictor1 (`comp_scheme` = 5'b01001).** Stimulus: first two beats of a line, X=0x100 and X=0x104. Required: both are PCM, codes 0x40 and 0x41.
- **Backpressure.** Hold `out_ready` = 0 with `out_valid` = 1 for 3 cycles. Required:
  - `pix_ready` = 0, `enable` = 0 and `out_data` unchanged for those 3 cycles.
  - On release, a back-to-back stream runs at one beat per cycle.
- **Bypass** (`comp_scheme` = 0). Stimulus: X=0xABC. Required:
  - `out_data` = 0xABC one cycle later.
  - `enable` and all `pixelk_valid` stay 0.
- **Reset mid-line.** Assert `sys_rst_n` low after beat 3. Required:
  - `out_valid` drops immediately.
  - The first beat after reset asserts `pixel1_valid` without `pix_sol`.
